// File: rtl/reorder_buffer_nway_if.sv
// reorder_buffer_nway_if: dispatch, CDB, lookup and retire
// signals of the N-wide reorder buffer. slave = ROB, master = core.
interface reorder_buffer_nway_if #(
  parameter int TAG_W = 4,
  parameter int WIDTH = 2,
  parameter int CDBS  = 2,
  parameter int XLEN  = 64,
  parameter int REG_W = 5
);
  logic                      flush;
  logic [WIDTH-1:0]          disp_valid;
  logic [WIDTH*REG_W-1:0]    disp_dest;
  logic                      disp_accept;
  logic [WIDTH*TAG_W-1:0]    disp_tag;
  logic [CDBS-1:0]           cdb_valid;
  logic [CDBS*TAG_W-1:0]     cdb_tag;
  logic [CDBS*XLEN-1:0]      cdb_value;
  logic [2*WIDTH*TAG_W-1:0]  rd_tag;
  logic [2*WIDTH-1:0]        rd_ready;
  logic [2*WIDTH*XLEN-1:0]   rd_value;
  logic [WIDTH-1:0]          ret_valid;
  logic [WIDTH*REG_W-1:0]    ret_dest;
  logic [WIDTH*XLEN-1:0]     ret_value;
  logic [TAG_W:0]            free_count;
  logic                      rob_empty;
  logic                      rob_full;

  modport slave (
    input  flush, disp_valid, disp_dest,
    input  cdb_valid, cdb_tag, cdb_value, rd_tag,
    output disp_accept, disp_tag, rd_ready, rd_value,
    output ret_valid, ret_dest, ret_value,
    output free_count, rob_empty, rob_full
  );

  modport master (
    output flush, disp_valid, disp_dest,
    output cdb_valid, cdb_tag, cdb_value, rd_tag,
    input  disp_accept, disp_tag, rd_ready, rd_value,
    input  ret_valid, ret_dest, ret_value,
    input  free_count, rob_empty, rob_full
  );
endinterface

// File: rtl/reorder_buffer_nway.sv
// reorder_buffer_nway: circular ROB, WIDTH-wide dispatch/retire,
// CDBS result buses, tag lookup with CDB bypass, flush. Ports: clock, reset, rob.
module reorder_buffer_nway #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 4,
  parameter int WIDTH   = 2,
  parameter int CDBS    = 2,
  parameter int XLEN    = 64,
  parameter int REG_W   = 5
) (
  input logic                  clock,
  input logic                  reset,
  reorder_buffer_nway_if.slave rob
);
  localparam int RD = 2 * WIDTH;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    DONE
  } slot_e;

  slot_e            st_q   [ENTRIES];
  logic [REG_W-1:0] dest_q [ENTRIES];
  logic [XLEN-1:0]  val_q  [ENTRIES];
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   cnt_q;

  logic [TAG_W:0]   k;
  logic [TAG_W:0]   r;
  logic [TAG_W:0]   free;
  logic             acc;
  logic             go;
  logic [TAG_W-1:0] lane_tag [WIDTH];
  logic [TAG_W-1:0] ret_slot [WIDTH];
  logic [TAG_W-1:0] rd_slot  [RD];
  logic [WIDTH-1:0] ret_v;
  logic [ENTRIES-1:0] cdb_hit;
  logic [XLEN-1:0]  cdb_val [ENTRIES];

  assign free = (TAG_W+1)'(ENTRIES) - cnt_q;
  assign acc  = (k <= free) && !rob.flush;

  assign rob.disp_accept = acc;
  assign rob.free_count  = free;
  assign rob.rob_empty   = cnt_q == '0;
  assign rob.rob_full    = cnt_q == (TAG_W+1)'(ENTRIES);
  assign rob.ret_valid   = ret_v;

  // Lanes are compacted: each takes tail plus the
  // number of requesting lanes below it.
  always_comb begin
    k = '0;
    rob.disp_tag = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_tag[i] = tail_q + k[TAG_W-1:0];
      rob.disp_tag[i*TAG_W +: TAG_W] = lane_tag[i];
      if (rob.disp_valid[i])
        k = k + (TAG_W+1)'(1);
    end
  end

  // Descending bus scan so the lowest bus wins a tag clash.
  always_comb begin
    for (int s = 0; s < ENTRIES; s++) begin
      cdb_hit[s] = 1'b0;
      cdb_val[s] = '0;
      for (int b = CDBS - 1; b >= 0; b--) begin
        if (rob.cdb_valid[b] &&
            rob.cdb_tag[b*TAG_W +: TAG_W] == TAG_W'(s)) begin
          cdb_hit[s] = 1'b1;
          cdb_val[s] = rob.cdb_value[b*XLEN +: XLEN];
        end
      end
      cdb_hit[s] = cdb_hit[s] && (st_q[s] == BUSY);
    end
  end

  always_comb begin
    rob.rd_ready = '0;
    rob.rd_value = '0;
    for (int q = 0; q < RD; q++) begin
      rd_slot[q] = rob.rd_tag[q*TAG_W +: TAG_W];
      case (st_q[rd_slot[q]])
        DONE: begin
          rob.rd_ready[q] = 1'b1;
          rob.rd_value[q*XLEN +: XLEN] = val_q[rd_slot[q]];
        end
        BUSY: begin
          rob.rd_ready[q] = cdb_hit[rd_slot[q]];
          rob.rd_value[q*XLEN +: XLEN] = cdb_hit[rd_slot[q]] ?
            cdb_val[rd_slot[q]] : val_q[rd_slot[q]];
        end
        default: ;
      endcase
    end
  end

  // Retire a contiguous run of DONE slots from head;
  // uses registered state only, so a same-cycle CDB
  // result waits one cycle.
  always_comb begin
    r  = '0;
    go = !rob.flush;
    rob.ret_dest  = '0;
    rob.ret_value = '0;
    for (int j = 0; j < WIDTH; j++) begin
      ret_slot[j] = head_q + TAG_W'(j);
      go = go && (st_q[ret_slot[j]] == DONE);
      ret_v[j] = go;
      rob.ret_dest[j*REG_W +: REG_W] = dest_q[ret_slot[j]];
      rob.ret_value[j*XLEN +: XLEN]  = val_q[ret_slot[j]];
      if (go)
        r = r + (TAG_W+1)'(1);
    end
  end

  // Dispatch writes only EMPTY slots, CDB only BUSY,
  // retire only DONE, so the updates never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < ENTRIES; s++) begin
        st_q[s]   <= EMPTY;
        dest_q[s] <= '0;
        val_q[s]  <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (rob.flush) begin
      for (int s = 0; s < ENTRIES; s++)
        st_q[s] <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int s = 0; s < ENTRIES; s++) begin
        if (cdb_hit[s]) begin
          st_q[s]  <= DONE;
          val_q[s] <= cdb_val[s];
        end
      end
      for (int j = 0; j < WIDTH; j++)
        if (ret_v[j])
          st_q[ret_slot[j]] <= EMPTY;
      if (acc) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (rob.disp_valid[i]) begin
            st_q[lane_tag[i]]   <= BUSY;
            dest_q[lane_tag[i]] <=
              rob.disp_dest[i*REG_W +: REG_W];
            val_q[lane_tag[i]]  <= '0;
          end
        end
        tail_q <= tail_q + k[TAG_W-1:0];
      end
      head_q <= head_q + r[TAG_W-1:0];
      cnt_q  <= cnt_q + (acc ? k : '0) - r;
    end
  end
endmodule

// File: tb/tb_reorder_buffer_nway.sv
// tb_reorder_buffer_nway: directed checks of the ROB
// with immediate assertions and a summary line.
module tb_reorder_buffer_nway;
  logic clock;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;

  reorder_buffer_nway_if #(
    .TAG_W(4), .WIDTH(2), .CDBS(2), .XLEN(64), .REG_W(5)
  ) rob ();

  reorder_buffer_nway #(
    .ENTRIES(16), .TAG_W(4), .WIDTH(2),
    .CDBS(2), .XLEN(64), .REG_W(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rob(rob)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    rob.flush      = 1'b0;
    rob.disp_valid = '0;
    rob.disp_dest  = '0;
    rob.cdb_valid  = '0;
    rob.cdb_tag    = '0;
    rob.cdb_value  = '0;
    rob.rd_tag     = '0;
  endtask

  task automatic cdb(input logic [1:0] v,
                     input logic [3:0] t1, input logic [3:0] t0,
                     input logic [63:0] x1, input logic [63:0] x0);
    rob.cdb_valid = v;
    rob.cdb_tag   = {t1, t0};
    rob.cdb_value = {x1, x0};
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #3;
    chk("rst_free", rob.free_count, 16);
    chk("rst_empty", rob.rob_empty, 1);
    chk("rst_full", rob.rob_full, 0);
    chk("rst_ret", rob.ret_valid, 0);
    chk("rst_rd", rob.rd_ready, 0);
    chk("rst_acc", rob.disp_accept, 1);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // 1: basic dispatch, out-of-order complete, dual retire
    rob.disp_valid = 2'b11;
    rob.disp_dest  = {5'd7, 5'd3};
    #1;
    chk("t1_tag", rob.disp_tag, 8'h10);
    chk("t1_acc", rob.disp_accept, 1);
    tick();
    idle();
    #1;
    chk("t1_free", rob.free_count, 14);
    cdb(2'b01, 4'd0, 4'd1, 64'h0, 64'hAA);
    tick();
    cdb(2'b01, 4'd0, 4'd0, 64'h0, 64'h55);
    #1;
    chk("t1_noret", rob.ret_valid, 0);
    tick();
    idle();
    #1;
    chk("t1_ret", rob.ret_valid, 2'b11);
    chk("t1_dest", rob.ret_dest, {5'd7, 5'd3});
    chk("t1_val", rob.ret_value, {64'hAA, 64'h55});
    tick();
    chk("t1_empty", rob.rob_empty, 1);

    // 2: fill from head = tail = 2, then retire while full
    for (int i = 0; i < 8; i++) begin
      rob.disp_valid = 2'b11;
      rob.disp_dest  = {5'(2 * i + 1), 5'(2 * i)};
      #1;
      chk("t2_fillacc", rob.disp_accept, 1);
      tick();
    end
    idle();
    #1;
    chk("t2_full", rob.rob_full, 1);
    chk("t2_free0", rob.free_count, 0);
    rob.disp_valid = 2'b01;
    #1;
    chk("t2_rej", rob.disp_accept, 0);
    tick();
    idle();
    #1;
    chk("t2_hold", rob.free_count, 0);
    rob.disp_valid = 2'b11;
    cdb(2'b11, 4'd3, 4'd2, 64'h33, 64'h22);
    #1;
    chk("t2_rej2", rob.disp_accept, 0);
    tick();
    cdb(2'b00, 4'd0, 4'd0, 64'h0, 64'h0);
    #1;
    chk("t2_ret", rob.ret_valid, 2'b11);
    chk("t2_nofwd", rob.disp_accept, 0);
    tick();
    chk("t2_acc", rob.disp_accept, 1);
    chk("t2_wrap", rob.disp_tag, 8'h32);
    tick();
    idle();
    #1;
    chk("t2_full2", rob.rob_full, 1);

    rob.flush = 1'b1;
    #1;
    tick();
    idle();

    // 3: advance head/tail to 15, then wrap
    for (int i = 0; i < 7; i++) begin
      rob.disp_valid = 2'b11;
      rob.disp_dest  = {5'd1, 5'd1};
      tick();
    end
    rob.disp_valid = 2'b01;
    tick();
    idle();
    for (int c = 0; c < 8; c++) begin
      cdb(2'b11, 4'(2 * c + 1), 4'(2 * c), 64'h1, 64'h1);
      tick();
    end
    idle();
    tick();
    tick();
    chk("t3_empty", rob.rob_empty, 1);
    chk("t3_free", rob.free_count, 16);
    rob.disp_valid = 2'b10;
    rob.disp_dest  = {5'd9, 5'd0};
    #1;
    chk("t3_acc", rob.disp_accept, 1);
    chk("t3_tag15", rob.disp_tag[7:4], 4'hF);
    tick();
    rob.disp_valid = 2'b11;
    rob.disp_dest  = {5'd11, 5'd10};
    #1;
    chk("t3_tag01", rob.disp_tag, 8'h10);
    tick();
    idle();

    // 5: in-order commit across the wrap
    cdb(2'b01, 4'd0, 4'd0, 64'h0, 64'h100);
    #1;
    chk("t5_r0", rob.ret_valid, 0);
    tick();
    idle();
    #1;
    chk("t5_ooo", rob.ret_valid, 0);
    cdb(2'b01, 4'd0, 4'd15, 64'h0, 64'hF00);
    #1;
    chk("t5_same", rob.ret_valid, 0);
    tick();
    idle();
    #1;
    chk("t5_ret", rob.ret_valid, 2'b11);
    chk("t5_dest", rob.ret_dest, {5'd10, 5'd9});
    chk("t5_val", rob.ret_value, {64'h100, 64'hF00});
    tick();

    // 4: lookup with same-cycle bypass and bus priority
    rob.disp_valid = 2'b11;
    rob.disp_dest  = {5'd13, 5'd12};
    tick();
    rob.disp_dest  = {5'd15, 5'd14};
    #1;
    chk("t4_tag", rob.disp_tag, 8'h54);
    tick();
    idle();
    rob.rd_tag = {4'd5, 4'd0, 4'd1, 4'd5};
    #1;
    chk("t4_busy", rob.rd_ready, 4'b0000);
    cdb(2'b11, 4'd5, 4'd5, 64'h9999, 64'h1234);
    #1;
    chk("t4_byp", rob.rd_ready, 4'b1001);
    chk("t4_bv0", rob.rd_value[63:0], 64'h1234);
    chk("t4_bv3", rob.rd_value[255:192], 64'h1234);
    chk("t4_empty", rob.rd_value[191:128], 64'h0);
    tick();
    cdb(2'b00, 4'd0, 4'd0, 64'h0, 64'h0);
    #1;
    chk("t4_done", rob.rd_ready, 4'b1001);
    chk("t4_stored", rob.rd_value[63:0], 64'h1234);
    idle();

    // 6: flush with 6 live entries, then async reset
    rob.disp_valid = 2'b01;
    rob.disp_dest  = {5'd0, 5'd20};
    tick();
    idle();
    cdb(2'b01, 4'd0, 4'd1, 64'h0, 64'h77);
    tick();
    idle();
    #1;
    chk("t6_ret1", rob.ret_valid, 2'b01);
    chk("t6_free", rob.free_count, 10);
    rob.flush      = 1'b1;
    rob.disp_valid = 2'b11;
    cdb(2'b01, 4'd0, 4'd2, 64'h0, 64'h88);
    #1;
    chk("t6_fret", rob.ret_valid, 0);
    chk("t6_facc", rob.disp_accept, 0);
    tick();
    idle();
    #1;
    chk("t6_free16", rob.free_count, 16);
    chk("t6_empty", rob.rob_empty, 1);
    rob.disp_valid = 2'b11;
    #1;
    chk("t6_tag", rob.disp_tag, 8'h10);
    tick();
    idle();
    #1;
    chk("t6_free14", rob.free_count, 14);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_arst", rob.rob_empty, 1);
    chk("t6_afree", rob.free_count, 16);
    #1;
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_nway.md
Name: reorder_buffer_nway

Overview:
Parametrised N-wide circular reorder buffer for the out-of-order core. Sits between dispatch and the reservation stations and architectural register file.
- Allocates up to WIDTH entries per cycle in program order.
- Captures results from CDBS common data buses.
- Services operand lookups by tag.
- Retires up to WIDTH completed entries per cycle in order.
- Adds a pipeline flush that the two-wide original did not have.

Parameters:
ENTRIES, 16, number of ROB slots; power of two, at least 2*WIDTH
TAG_W, 4, log2(ENTRIES); a tag equals the slot index
WIDTH, 2, dispatch and retire lanes per cycle
CDBS, 2, number of CDB write ports
XLEN, 64, result value width
REG_W, 5, architectural destination register index width

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
flush  in  1  synchronous squash of every entry
disp_valid  in  WIDTH  per-lane dispatch request
disp_dest  in  WIDTH*REG_W  per-lane destination register
disp_accept  out  1  all requested lanes were allocated this cycle
disp_tag  out  WIDTH*TAG_W  allocated tag per lane; meaningful only when disp_valid[i] and disp_accept are both 1
cdb_valid  in  CDBS  CDB broadcast valid
cdb_tag  in  CDBS*TAG_W  CDB tag
cdb_value  in  CDBS*XLEN  CDB result
rd_tag  in  2*WIDTH*TAG_W  operand lookup tags from the RS
rd_ready  out  2*WIDTH  looked-up entry has its value available
rd_value  out  2*WIDTH*XLEN  looked-up value, forwarded from the CDB in the same cycle if needed
ret_valid  out  WIDTH  lane commits this cycle
ret_dest  out  WIDTH*REG_W  committed destination register
ret_value  out  WIDTH*XLEN  committed value
free_count  out  TAG_W+1  number of empty slots
rob_empty  out  1  free_count == ENTRIES
rob_full  out  1  free_count == 0

Behaviour:
- State:
  - Per entry: state EMPTY / BUSY / DONE, dest, value.
  - head, tail (TAG_W bits, wrap modulo ENTRIES), count (TAG_W+1 bits).
- Reset (asynchronous):
  - All entries EMPTY; head = tail = count = 0.
  - Outputs: free_count = ENTRIES, rob_empty = 1, rob_full = 0, ret_valid = 0, rd_ready = 0, disp_accept = 1 when no lanes are requested.
- Dispatch:
  - Let k = popcount(disp_valid). Lanes are compacted: lane i gets slot tail + (number of valid lanes below i).
  - Accept is all-or-nothing: disp_accept = (k <= free_count) && !flush. free_count is taken from the start of the cycle; slots freed by same-cycle retirement are not forwarded.
  - On accept, the k slots become BUSY with dest loaded and value cleared, and tail += k.
  - disp_tag is combinational, with zero-cycle latency.
- CDB:
  - For each valid bus, the slot at cdb_tag goes BUSY -> DONE and latches cdb_value.
  - A CDB hit on an EMPTY or DONE slot is ignored.
  - If two buses carry the same tag, the lower-numbered bus wins.
- Lookup (combinational):
  - rd_ready = slot is DONE, or slot is BUSY and a valid CDB matches rd_tag this cycle.
  - rd_value comes from the CDB when bypassing, otherwise from the stored value.
  - If the slot is EMPTY, rd_ready = 0 and rd_value = 0.
- Retire:
  - ret_valid[j] = 1 when slot head+j is DONE and every lane below j is also retiring. Retirement is in order and never skips an entry.
  - A result arriving on the CDB this cycle does not retire until the next cycle.
  - ret outputs are combinational. At the edge the retiring slots become EMPTY and head += r.
- Count: count_next = count + k_accepted - r. Simultaneous dispatch and retire are legal, including at full and at empty.
- Wrap-around: head, tail and compacted lane indices all wrap modulo ENTRIES.
- Flush:
  - Has priority over dispatch, CDB and retire.
  - While flush = 1: ret_valid = 0 and disp_accept = 0.
  - At the edge: all entries EMPTY, head = tail = count = 0.
- Reset asserted mid-operation discards everything immediately, with no clock edge required.
- Lanes whose disp_valid bit is 0 while disp_accept = 0 have undefined disp_tag; consumers must ignore them.

Test Plan:
1. Reset, then dispatch 2 entries (dest 3, 7) -> disp_tag = 0, 1; free_count = 14. CDB tag 1 = 0xAA, then tag 0 = 0x55 -> the next cycle ret_valid = 2'b11, ret_dest = 3/7, ret_value = 0x55/0xAA; then rob_empty = 1.
2. Fill with 8 double dispatches -> rob_full = 1. Next request of 1 lane -> disp_accept = 0 and state unchanged. Retire 2 while requesting 2 -> accepted on the following cycle, tail wraps to 2.
3. disp_valid = 2'b10 with tail = 15 -> lane 1 gets tag 15; the next pair gets tags 0, 1 (wrap check).
4. Entry 5 BUSY, cdb_valid with tag 5 = 0x1234 and rd_tag = 5 in the same cycle -> rd_ready = 1, rd_value = 0x1234. Both CDBs on tag 5 -> bus 0 value stored.
5. Head BUSY, head+1 DONE -> ret_valid = 0 (no out-of-order commit). Complete head -> ret_valid = 2'b11.
6. With 6 live entries, assert flush together with dispatch and CDB -> no commit, disp_accept = 0, then free_count = 16. Assert reset between clock edges -> rob_empty = 1 immediately.
